// File: rtl/md_pkg.sv
// Shared constants for the multiply/divide unit and the write-back mux.
//   - md_op encodings (MD_MULT .. MD_MSUB)
//   - mult_div_unit state encoding
//   - default latencies for the counter-modelled arithmetic
//   - write-back select codes, including the HI/LO read paths
package md_pkg;

   localparam logic [2:0] MD_MULT  = 3'd0;
   localparam logic [2:0] MD_MULTU = 3'd1;
   localparam logic [2:0] MD_DIV   = 3'd2;
   localparam logic [2:0] MD_DIVU  = 3'd3;
   localparam logic [2:0] MD_MTHI  = 3'd4;
   localparam logic [2:0] MD_MTLO  = 3'd5;
   localparam logic [2:0] MD_MADD  = 3'd6;
   localparam logic [2:0] MD_MSUB  = 3'd7;

   typedef enum logic {
      MD_IDLE = 1'b0,
      MD_BUSY = 1'b1
   } md_state_t;

   localparam int MD_MULT_CYCLES_DEF = 5;
   localparam int MD_DIV_CYCLES_DEF  = 10;

   // Write-back select codes; HI/LO occupy the mux's spare inputs.
   localparam logic [2:0] WB_SEL_ALU = 3'd0;
   localparam logic [2:0] WB_SEL_MEM = 3'd1;
   localparam logic [2:0] WB_SEL_PC8 = 3'd2;
   localparam logic [2:0] WB_SEL_HI  = 3'd3;
   localparam logic [2:0] WB_SEL_LO  = 3'd4;

endpackage

// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle multiply/divide with architectural HI/LO.
// The arithmetic is evaluated on the accept edge and held in pend_hi/pend_lo;
// a down-counter models the latency and commits to HI/LO at terminal count.
//
// Optional feature macro: MD_MADD_EN (md_op 6 = MADD, 7 = MSUB, signed
// 64-bit accumulate into {hi,lo}). Undefined: 6/7 are no-ops.
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-high reset
//   start  in   issue md_op this cycle
//   md_op  in   [2:0] operation select (md_pkg encodings)
//   a      in   [31:0] rs operand
//   b      in   [31:0] rt operand
//   busy   out  operation in flight
//   hi     out  [31:0] architectural HI
//   lo     out  [31:0] architectural LO
//
// state   | meaning
// --------+-----------------------------------------------
// MD_IDLE | no operation in flight, start accepted
// MD_BUSY | result pending, counting down to commit
module mult_div_unit
   import md_pkg::*;
#(
   parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  md_op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

   md_state_t         state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [31:0]       pend_hi_q, pend_hi_d;
   logic [31:0]       pend_lo_q, pend_lo_d;
   logic              pend_ok_q, pend_ok_d;
   logic [31:0]       hi_q, hi_d;
   logic [31:0]       lo_q, lo_d;

   logic [63:0]        prod_s;
   logic [63:0]        prod_u;
   logic               div_ovf;
   logic signed [31:0] dvs_s;
   logic signed [31:0] quo_s;
   logic signed [31:0] rem_s;
   logic [31:0]        dvs_u;
   logic [31:0]        quo_u;
   logic [31:0]        rem_u;

   assign prod_s = $unsigned($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}));
   assign prod_u = {32'd0, a} * {32'd0, b};

   // A divisor of 1 stands in for both b==0 (result discarded) and the
   // 0x80000000 / -1 overflow, whose architectural result is exactly a / 1.
   assign div_ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
   assign dvs_s   = (b == 32'd0 || div_ovf) ? 32'sd1 : $signed(b);
   assign quo_s   = $signed(a) / dvs_s;
   assign rem_s   = $signed(a) % dvs_s;
   assign dvs_u   = (b == 32'd0) ? 32'd1 : b;
   assign quo_u   = a / dvs_u;
   assign rem_u   = a % dvs_u;

`ifdef MD_MADD_EN
   logic [63:0] acc_add;
   logic [63:0] acc_sub;
   assign acc_add = {hi_q, lo_q} + prod_s;
   assign acc_sub = {hi_q, lo_q} - prod_s;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= MD_IDLE;
         cnt_q     <= '0;
         pend_hi_q <= '0;
         pend_lo_q <= '0;
         pend_ok_q <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pend_hi_q <= pend_hi_d;
         pend_lo_q <= pend_lo_d;
         pend_ok_q <= pend_ok_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pend_hi_d = pend_hi_q;
      pend_lo_d = pend_lo_q;
      pend_ok_d = pend_ok_q;
      hi_d      = hi_q;
      lo_d      = lo_q;

      case (state_q)
         MD_IDLE: begin
            if (start) begin
               case (md_op)
                  MD_MULT: begin
                     {pend_hi_d, pend_lo_d} = prod_s;
                     pend_ok_d = 1'b1;
                     cnt_d     = CNT_W'(MULT_CYCLES);
                     state_d   = MD_BUSY;
                  end
                  MD_MULTU: begin
                     {pend_hi_d, pend_lo_d} = prod_u;
                     pend_ok_d = 1'b1;
                     cnt_d     = CNT_W'(MULT_CYCLES);
                     state_d   = MD_BUSY;
                  end
                  MD_DIV: begin
                     pend_lo_d = $unsigned(quo_s);
                     pend_hi_d = $unsigned(rem_s);
                     pend_ok_d = (b != 32'd0);
                     cnt_d     = CNT_W'(DIV_CYCLES);
                     state_d   = MD_BUSY;
                  end
                  MD_DIVU: begin
                     pend_lo_d = quo_u;
                     pend_hi_d = rem_u;
                     pend_ok_d = (b != 32'd0);
                     cnt_d     = CNT_W'(DIV_CYCLES);
                     state_d   = MD_BUSY;
                  end
                  MD_MTHI: hi_d = a;
                  MD_MTLO: lo_d = a;
`ifdef MD_MADD_EN
                  MD_MADD: begin
                     {pend_hi_d, pend_lo_d} = acc_add;
                     pend_ok_d = 1'b1;
                     cnt_d     = CNT_W'(MULT_CYCLES);
                     state_d   = MD_BUSY;
                  end
                  MD_MSUB: begin
                     {pend_hi_d, pend_lo_d} = acc_sub;
                     pend_ok_d = 1'b1;
                     cnt_d     = CNT_W'(MULT_CYCLES);
                     state_d   = MD_BUSY;
                  end
`endif
                  default: ;
               endcase
            end
         end
         MD_BUSY: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
               state_d = MD_IDLE;
               if (pend_ok_q) begin
                  hi_d = pend_hi_q;
                  lo_d = pend_lo_q;
               end
            end
         end
         default: state_d = MD_IDLE;
      endcase
   end

   assign busy = (state_q == MD_BUSY);
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Multi-cycle integer multiply/divide unit with architectural HI/LO registers for the pipelined MIPS CPU. Sits in the execute stage beside the ALU. Its HI/LO read value feeds a spare input of the 32-bit write-back select mux, driven by MFHI/MFLO. The hazard unit stalls on its `busy` output.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for MULT/MULTU (≥1).
- `DIV_CYCLES`, default 10: busy cycles for DIV/DIVU (≥1).
- `clk` input, 1: rising-edge clock.
- `reset` input, 1: asynchronous, active-high reset.
- `start` input, 1: issue `md_op` this cycle (E stage, not stalled, not flushed).
- `md_op` input, 3: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 reserved (see Configuration).
- `a` input, 32: rs operand.
- `b` input, 32: rt operand.
- `busy` output, 1: operation in flight.
- `hi` output, 32: architectural HI.
- `lo` output, 32: architectural LO.

## Operation
- States: IDLE, BUSY.
- Accept rule: in IDLE with `start`=1, the op is accepted. In BUSY, `start` is ignored; the hazard unit guarantees it never issues then.
- MULT/MULTU, accept edge: compute 64-bit signed/unsigned product into `pend_hi`/`pend_lo`, load `cnt`=MULT_CYCLES, go BUSY.
- DIV/DIVU, accept edge: compute quotient into `pend_lo` and remainder into `pend_hi`, load `cnt`=DIV_CYCLES, go BUSY.
  - Signed division truncates toward zero; the remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF (signed) gives LO=0x80000000, HI=0.
  - Divide by zero (`b`=0): go BUSY for the full DIV_CYCLES, then commit nothing; HI/LO keep their old values.
- MTHI/MTLO, accept edge: `hi` or `lo` gets `a` directly. No BUSY entry, no counter.
- BUSY: `cnt` decrements each edge. On the edge where `cnt`==1, commit pend→hi/lo and return to IDLE.
- Reserved opcodes with `start`=1: no-op, stay IDLE.
- `md_op`, `a` and `b` are don't-care when `start`=0.

## Timing
- Reset (async, any state): state=IDLE, `busy`=0, `hi`=0, `lo`=0, `cnt`=0, pending values discarded.
- `busy` is registered. It is 1 in exactly the N cycles after the accept edge (N = MULT_CYCLES or DIV_CYCLES), and 0 otherwise.
- `hi`/`lo` are registered and change only on the accept edge (MTHI/MTLO) or the commit edge (N edges after accept).
- Reads of `hi`/`lo` during BUSY return the old values. The hazard unit stalls MFHI/MFLO while `busy`=1.
- `start` in the cycle right after commit (`busy` just fell) is accepted normally: back-to-back operation, no bubble.
- Reset asserted mid-BUSY aborts the operation. The first accept after reset release behaves as from power-on.

## Configuration
- `MD_MADD_EN` defined: `md_op` 6 = MADD ({hi,lo} += signed a*b) and 7 = MSUB ({hi,lo} -= signed a*b).
  - Both take MULT_CYCLES.
  - The 64-bit accumulate uses {hi,lo} as of the accept edge and wraps modulo 2^64.
- `MD_MADD_EN` undefined: 6/7 are reserved no-ops; no accumulate logic is synthesised.

## Structure
- Shared package `md_pkg` holds:
  - the `md_op` encodings, named localparams MD_MULT … MD_MSUB;
  - the state encoding;
  - default cycle counts.
- Write-back select code for HI/LO lives alongside the existing mux control constants.
- No sub-module: the arithmetic is inline behavioural `*`, `/`, `%` on the accept edge, with the counter modelling latency. A future iterative divider would replace it as `md_div_iter`.

## Test plan
- Reset then MULT a=0xFFFFFFFF, b=2 → `busy`=1 for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- MULTU a=0xFFFFFFFF, b=2 → after 5 cycles hi=0x00000001, lo=0xFFFFFFFE.
- DIV a=0xFFFFFFF9 (-7), b=2 → `busy` for 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/0 afterwards → busy 10 cycles, hi/lo unchanged.
- MTHI a=0x12345678 while IDLE → hi=0x12345678 next cycle, `busy` stays 0. `start`=1 with MTLO mid-DIV → ignored, lo unchanged.
- DIV started, `reset` pulsed at busy cycle 4 → `busy`, hi, lo all 0 immediately (async); no later commit.
- Back-to-back: MULT 3*4, then MULT 5*6 issued the cycle `busy` falls → lo=12, then lo=30 five cycles later. With `MD_MADD_EN`, MADD 2*3 on {0,12} → lo=18.
